icache_refill: RTL and testbench

Instruction-cache refill engine: accepts one miss from the fetch stage, issues a line-aligned read to the memory bus, assembles the 8-beat response into a full line, and drives the cache array's write port (wren/widx/wtag/wdat). It is the writer for the 4-way, 256-set instruction cache array. It honours invalidates and flushes that race an in-flight refill, so a stale line is never installed.

---
 rtl/icache_refill_pkg.sv | 37 +++
 rtl/icache_refill_linebuf.sv | 55 +++++
 rtl/icache_refill.sv | 164 ++++++++++++++++
 tb/tb_icache_refill.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_pkg.sv
// -----------------------------------------------------------------------------
// icache_refill_pkg
// Shared definitions for the instruction-cache refill engine and the cache
// array it writes: address/line geometry, refill state encoding, and the
// tag/index slice helpers (tag = paddr[33:14], idx = paddr[13:6]) that the
// array's flush logic uses as well.
// -----------------------------------------------------------------------------
package icache_refill_pkg;

    localparam int PHY_ADDR_WIDTH    = 34;
    localparam int ICACHE_TAG_WIDTH  = 20;
    localparam int ICACHE_IDX_WIDTH  = 8;
    localparam int ICACHE_DATA_WIDTH = 512;
    localparam int ICACHE_OFS_WIDTH  = 6;
    localparam int ICACHE_BEAT_WIDTH = 64;
    localparam int ICACHE_BEAT_CNT   = ICACHE_DATA_WIDTH / ICACHE_BEAT_WIDTH;

    typedef enum logic [1:0] {
        REFILL_IDLE  = 2'd0,
        REFILL_REQ   = 2'd1,
        REFILL_RESP  = 2'd2,
        REFILL_WRITE = 2'd3
    } refill_state_e;

    function automatic logic [ICACHE_TAG_WIDTH-1:0] icache_tag_of(
        input logic [PHY_ADDR_WIDTH-1:0] paddr
    );
        return paddr[PHY_ADDR_WIDTH-1 -: ICACHE_TAG_WIDTH];
    endfunction

    function automatic logic [ICACHE_IDX_WIDTH-1:0] icache_idx_of(
        input logic [PHY_ADDR_WIDTH-1:0] paddr
    );
        return paddr[ICACHE_OFS_WIDTH +: ICACHE_IDX_WIDTH];
    endfunction

endpackage

// File: rtl/icache_refill_linebuf.sv
// -----------------------------------------------------------------------------
// icache_refill_linebuf
// Line assembly buffer: BEATS registers of BEAT_W bits, one written per
// response beat at the slot selected by the beat index. Contents persist
// between refills; slots not written by a short response keep old data.
//   clk, rst     : clock, asynchronous active-high reset (clears the buffer)
//   i_we         : write the beat this cycle
//   i_beat_idx   : slot to write
//   i_beat_data  : beat payload
//   o_line       : concatenated line, slot k at bits [k*BEAT_W +: BEAT_W]
// -----------------------------------------------------------------------------
module icache_refill_linebuf
    import icache_refill_pkg::*;
#(
    parameter int BEAT_W = ICACHE_BEAT_WIDTH,
    parameter int BEATS  = ICACHE_BEAT_CNT,
    parameter int CNT_W  = $clog2(BEATS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [CNT_W-1:0]        i_beat_idx,
    input  logic [BEAT_W-1:0]       i_beat_data,
    output logic [BEATS*BEAT_W-1:0] o_line
);

    logic [BEAT_W-1:0] beat_q [BEATS];
    logic [BEAT_W-1:0] beat_d [BEATS];

    always_comb begin
        for (int b = 0; b < BEATS; b++) begin
            beat_d[b] = beat_q[b];
            if (i_we && (i_beat_idx == CNT_W'(b))) begin
                beat_d[b] = i_beat_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < BEATS; b++) begin
                beat_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < BEATS; b++) begin
                beat_q[b] <= beat_d[b];
            end
        end
    end

    for (genvar g = 0; g < BEATS; g++) begin : g_pack
        assign o_line[g*BEAT_W +: BEAT_W] = beat_q[g];
    end

endmodule

// File: rtl/icache_refill.sv
// -----------------------------------------------------------------------------
// icache_refill
// Instruction-cache refill engine. Accepts one miss, issues a line-aligned
// bus read, assembles the 8-beat response and writes the line into the cache
// array. Flushes and matching invalidates that race the refill kill it so a
// stale line is never installed.
//   clk, rst                         : clock, asynchronous active-high reset
//   i_miss_vld/i_miss_paddr/o_miss_rdy : miss request handshake
//   i_flush                          : pipeline flush, aborts the refill
//   i_icache_inv_vld/_paddr          : invalidate seen by the cache array
//   o_bus_req_vld/_addr, i_bus_req_rdy : bus read request
//   i_bus_rsp_vld/_data/_last/_err   : bus response beats (no backpressure)
//   o_icache_wren/_widx/_wtag/_wdat  : cache array write port
//   o_refill_done / o_refill_err     : one-cycle completion pulses
//   o_busy                           : engine not idle
// -----------------------------------------------------------------------------
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int PADDR_W = PHY_ADDR_WIDTH,
    parameter int TAG_W   = ICACHE_TAG_WIDTH,
    parameter int IDX_W   = ICACHE_IDX_WIDTH,
    parameter int LINE_W  = ICACHE_DATA_WIDTH,
    parameter int BEAT_W  = ICACHE_BEAT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_miss_vld,
    input  logic [PADDR_W-1:0] i_miss_paddr,
    output logic               o_miss_rdy,
    input  logic               i_flush,
    input  logic               i_icache_inv_vld,
    input  logic [PADDR_W-1:0] i_icache_inv_paddr,
    output logic               o_bus_req_vld,
    output logic [PADDR_W-1:0] o_bus_req_addr,
    input  logic               i_bus_req_rdy,
    input  logic               i_bus_rsp_vld,
    input  logic [BEAT_W-1:0]  i_bus_rsp_data,
    input  logic               i_bus_rsp_last,
    input  logic               i_bus_rsp_err,
    output logic               o_icache_wren,
    output logic [IDX_W-1:0]   o_icache_widx,
    output logic [TAG_W-1:0]   o_icache_wtag,
    output logic [LINE_W-1:0]  o_icache_wdat,
    output logic               o_refill_done,
    output logic               o_refill_err,
    output logic               o_busy
);

    localparam int LADDR_W = PADDR_W - ICACHE_OFS_WIDTH;
    localparam int BEATS   = LINE_W / BEAT_W;
    localparam int CNT_W   = $clog2(BEATS);

    refill_state_e      state_q, state_d;
    logic [LADDR_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               kill_q, kill_d;
    logic               err_q, err_d;

    logic               beat_fire;
    logic               beat_final_slot;
    logic               last_bad;
    logic               inv_match;
    logic [PADDR_W-1:0] line_paddr;

    // Byte offsets of miss/invalidate addresses never matter.
    logic unused_ofs;
    assign unused_ofs = ^{i_miss_paddr[ICACHE_OFS_WIDTH-1:0],
                          i_icache_inv_paddr[ICACHE_OFS_WIDTH-1:0]};

    assign line_paddr      = {line_q, {ICACHE_OFS_WIDTH{1'b0}}};
    assign inv_match       = i_icache_inv_vld &&
                             (i_icache_inv_paddr[PADDR_W-1:ICACHE_OFS_WIDTH] == line_q);
    assign beat_fire       = (state_q == REFILL_RESP) && i_bus_rsp_vld;
    assign beat_final_slot = (cnt_q == CNT_W'(BEATS - 1));
    // last must coincide exactly with the final slot; anything else is a
    // protocol error on the bus side.
    assign last_bad        = (i_bus_rsp_last != beat_final_slot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REFILL_IDLE;
            line_q  <= '0;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            REFILL_IDLE:  if (i_miss_vld) state_d = REFILL_REQ;
            REFILL_REQ: begin
                // Flush beats a same-cycle grant: the request never leaves.
                if (i_flush)            state_d = REFILL_IDLE;
                else if (i_bus_req_rdy) state_d = REFILL_RESP;
            end
            // Beat 7 ends collection even without last; later beats are dropped.
            REFILL_RESP:  if (beat_fire && (i_bus_rsp_last || beat_final_slot))
                              state_d = REFILL_WRITE;
            REFILL_WRITE: state_d = REFILL_IDLE;
            default:      state_d = REFILL_IDLE;
        endcase
    end

    always_comb begin
        line_d = line_q;
        cnt_d  = cnt_q;
        kill_d = kill_q;
        err_d  = err_q;
        if ((state_q == REFILL_IDLE) && i_miss_vld) begin
            line_d = i_miss_paddr[PADDR_W-1:ICACHE_OFS_WIDTH];
            cnt_d  = '0;
            kill_d = 1'b0;
            err_d  = 1'b0;
        end
        if (((state_q == REFILL_RESP) || (state_q == REFILL_WRITE)) && inv_match) begin
            kill_d = 1'b1;
        end
        // A flush during the response still drains beats, it only kills the install.
        if ((state_q == REFILL_RESP) && i_flush) begin
            kill_d = 1'b1;
        end
        if (beat_fire) begin
            cnt_d = cnt_q + 1'b1;
            if (i_bus_rsp_err || last_bad) err_d = 1'b1;
        end
    end

    always_comb begin
        o_miss_rdy     = (state_q == REFILL_IDLE);
        o_busy         = (state_q != REFILL_IDLE);
        o_bus_req_vld  = (state_q == REFILL_REQ) && !i_flush;
        o_bus_req_addr = line_paddr;
        // Same-cycle invalidate or flush must still block the install.
        o_icache_wren  = (state_q == REFILL_WRITE) && !kill_q && !err_q &&
                         !inv_match && !i_flush;
        o_refill_done  = o_icache_wren;
        o_refill_err   = (state_q == REFILL_WRITE) && err_q && !kill_q;
        o_icache_widx  = icache_idx_of(line_paddr);
        o_icache_wtag  = icache_tag_of(line_paddr);
    end

    icache_refill_linebuf #(
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS),
        .CNT_W  (CNT_W)
    ) u_linebuf (
        .clk         (clk),
        .rst         (rst),
        .i_we        (beat_fire),
        .i_beat_idx  (cnt_q),
        .i_beat_data (i_bus_rsp_data),
        .o_line      (o_icache_wdat)
    );

endmodule

// File: tb/tb_icache_refill.sv
// -----------------------------------------------------------------------------
// tb_icache_refill
// Self-checking bench for icache_refill: directed scenarios plus randomized
// refill transactions, with a transaction-level reference model compared
// against every DUT output on each falling clock edge.
// -----------------------------------------------------------------------------
module tb_icache_refill;

    localparam int PADDR_W = 34;
    localparam int TAG_W   = 20;
    localparam int IDX_W   = 8;
    localparam int LINE_W  = 512;
    localparam int BEAT_W  = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_miss_vld;
    logic [PADDR_W-1:0] i_miss_paddr;
    logic               o_miss_rdy;
    logic               i_flush;
    logic               i_icache_inv_vld;
    logic [PADDR_W-1:0] i_icache_inv_paddr;
    logic               o_bus_req_vld;
    logic [PADDR_W-1:0] o_bus_req_addr;
    logic               i_bus_req_rdy;
    logic               i_bus_rsp_vld;
    logic [BEAT_W-1:0]  i_bus_rsp_data;
    logic               i_bus_rsp_last;
    logic               i_bus_rsp_err;
    logic               o_icache_wren;
    logic [IDX_W-1:0]   o_icache_widx;
    logic [TAG_W-1:0]   o_icache_wtag;
    logic [LINE_W-1:0]  o_icache_wdat;
    logic               o_refill_done;
    logic               o_refill_err;
    logic               o_busy;

    always #5 clk = ~clk;

    icache_refill dut (
        .clk                (clk),
        .rst                (rst),
        .i_miss_vld         (i_miss_vld),
        .i_miss_paddr       (i_miss_paddr),
        .o_miss_rdy         (o_miss_rdy),
        .i_flush            (i_flush),
        .i_icache_inv_vld   (i_icache_inv_vld),
        .i_icache_inv_paddr (i_icache_inv_paddr),
        .o_bus_req_vld      (o_bus_req_vld),
        .o_bus_req_addr     (o_bus_req_addr),
        .i_bus_req_rdy      (i_bus_req_rdy),
        .i_bus_rsp_vld      (i_bus_rsp_vld),
        .i_bus_rsp_data     (i_bus_rsp_data),
        .i_bus_rsp_last     (i_bus_rsp_last),
        .i_bus_rsp_err      (i_bus_rsp_err),
        .o_icache_wren      (o_icache_wren),
        .o_icache_widx      (o_icache_widx),
        .o_icache_wtag      (o_icache_wtag),
        .o_icache_wdat      (o_icache_wdat),
        .o_refill_done      (o_refill_done),
        .o_refill_err       (o_refill_err),
        .o_busy             (o_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_line(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases of one refill transaction as seen from outside the block.
    typedef enum int {M_IDLE, M_REQ, M_RESP, M_WRITE} mph_e;
    mph_e        m_ph;
    logic [27:0] m_line;
    int          m_nb;
    bit          m_kill;
    bit          m_err;
    logic [63:0] m_lb [8];

    function automatic bit inv_hits();
        return (i_icache_inv_vld === 1'b1) && (i_icache_inv_paddr[33:6] == m_line);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph   <= M_IDLE;
            m_line <= '0;
            m_nb   <= 0;
            m_kill <= 1'b0;
            m_err  <= 1'b0;
            for (int k = 0; k < 8; k++) m_lb[k] <= '0;
        end else begin
            case (m_ph)
                M_IDLE: if (i_miss_vld) begin
                    m_line <= i_miss_paddr[33:6];
                    m_nb   <= 0;
                    m_kill <= 1'b0;
                    m_err  <= 1'b0;
                    m_ph   <= M_REQ;
                end
                M_REQ: begin
                    if (i_flush) m_ph <= M_IDLE;
                    else if (i_bus_req_rdy) m_ph <= M_RESP;
                end
                M_RESP: begin
                    if (i_flush || inv_hits()) m_kill <= 1'b1;
                    if (i_bus_rsp_vld) begin
                        m_lb[m_nb] <= i_bus_rsp_data;
                        // well-formed response: last asserted on the 8th beat and no other
                        if (i_bus_rsp_err || (i_bus_rsp_last != (m_nb == 7))) m_err <= 1'b1;
                        if (i_bus_rsp_last || (m_nb == 7)) m_ph <= M_WRITE;
                        m_nb <= m_nb + 1;
                    end
                end
                default: m_ph <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [511:0] e_wdat;
        logic [33:0]  e_paddr;
        bit           e_wren;
        if (chk_en) begin
            for (int k = 0; k < 8; k++) e_wdat[k*64 +: 64] = m_lb[k];
            e_paddr = {m_line, 6'b0};
            e_wren  = (m_ph == M_WRITE) && !m_kill && !m_err && !inv_hits() && !i_flush;
            chk("miss_rdy", o_miss_rdy, m_ph == M_IDLE);
            chk("busy", o_busy, m_ph != M_IDLE);
            chk("bus_req_vld", o_bus_req_vld, (m_ph == M_REQ) && !i_flush);
            chk("bus_req_addr", o_bus_req_addr, e_paddr);
            chk("wren", o_icache_wren, e_wren);
            chk("refill_done", o_refill_done, e_wren);
            chk("refill_err", o_refill_err, (m_ph == M_WRITE) && m_err && !m_kill);
            chk("widx", o_icache_widx, e_paddr[13:6]);
            chk("wtag", o_icache_wtag, e_paddr[33:14]);
            chk_line("wdat", o_icache_wdat, e_wdat);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        i_miss_vld       = 1'b0;
        i_flush          = 1'b0;
        i_icache_inv_vld = 1'b0;
        i_bus_req_rdy    = 1'b0;
        i_bus_rsp_vld    = 1'b0;
        i_bus_rsp_last   = 1'b0;
        i_bus_rsp_err    = 1'b0;
    endtask

    // One refill. last_at: beat carrying last (8 = never); err_at/flush_beat/
    // inv_beat: beat index for that event (-1 = none); flush_req: flush in REQ;
    // winv: 0 none, 1 other-line inv, 2 same-line inv in the WRITE cycle.
    // lit_wren/lit_err: hand-computed expectation for the WRITE cycle (-1 skip).
    task automatic run_txn(input logic [33:0] pa, input int last_at, input int err_at,
                           input bit flush_req, input int flush_beat, input int inv_beat,
                           input int winv, input bit wflush, input int extra,
                           input bit jitter, input int lit_wren, input int lit_err,
                           input bit lit_clean);
        int k;
        i_miss_paddr = pa;
        i_miss_vld   = 1'b1;
        step();
        i_miss_vld   = 1'b0;
        if (lit_clean) begin
            #1;
            chk("lit_req_addr", o_bus_req_addr, 34'h2_1234_5640);
            chk("lit_req_vld", o_bus_req_vld, 1'b1);
        end
        if (jitter) begin
            repeat ($urandom_range(0, 3)) step();
        end
        if (flush_req) begin
            i_flush       = 1'b1;
            i_bus_req_rdy = jitter ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            chk("lit_flush_no_req", o_bus_req_vld, 1'b0);
            step();
            clr_in();
            #1;
            chk("lit_flush_idle", o_busy, 1'b0);
            step();
            return;
        end
        i_bus_req_rdy = 1'b1;
        step();
        i_bus_req_rdy = 1'b0;
        k = 0;
        while (1) begin
            if (jitter && ($urandom_range(0, 3) == 0)) begin
                i_bus_rsp_vld = 1'b0;
                step();
                continue;
            end
            i_bus_rsp_vld  = 1'b1;
            i_bus_rsp_data = jitter ? {$urandom, $urandom} : 64'h1111_1111_1111_1111 + 64'(k);
            i_bus_rsp_last = (k == last_at);
            i_bus_rsp_err  = (k == err_at);
            i_flush        = (k == flush_beat);
            if (k == inv_beat) begin
                i_icache_inv_vld   = 1'b1;
                i_icache_inv_paddr = {pa[33:6], 6'h20};
            end else if (jitter && ($urandom_range(0, 9) == 0)) begin
                i_icache_inv_vld   = 1'b1;
                i_icache_inv_paddr = {2'($urandom_range(0, 3)), $urandom};
            end
            step();
            clr_in();
            if ((k == last_at) || (k == 7)) break;
            k++;
        end
        // WRITE cycle
        if (winv == 1) begin
            i_icache_inv_vld   = 1'b1;
            i_icache_inv_paddr = {pa[33:6] ^ 28'h1, 6'h00};
        end else if (winv == 2) begin
            i_icache_inv_vld   = 1'b1;
            i_icache_inv_paddr = {pa[33:6], 6'h3c};
        end
        i_flush = wflush;
        if (extra > 0) begin
            i_bus_rsp_vld  = 1'b1;
            i_bus_rsp_data = {$urandom, $urandom};
            i_bus_rsp_last = 1'($urandom_range(0, 1));
        end
        #1;
        if (lit_wren >= 0) chk("lit_wren", o_icache_wren, lit_wren[0]);
        if (lit_err >= 0)  chk("lit_err", o_refill_err, lit_err[0]);
        if (lit_clean) begin
            chk("lit_done", o_refill_done, 1'b1);
            chk("lit_widx", o_icache_widx, 8'h59);
            chk("lit_wtag", o_icache_wtag, 20'h848D1);
            for (int b = 0; b < 8; b++)
                chk("lit_wdat_beat", o_icache_wdat[b*64 +: 64], 64'h1111_1111_1111_1111 + 64'(b));
        end
        step();
        clr_in();
        for (int e = 1; e < extra; e++) begin
            i_bus_rsp_vld  = 1'b1;
            i_bus_rsp_data = {$urandom, $urandom};
            step();
            clr_in();
        end
        if (lit_wren >= 0 || lit_err >= 0) begin
            #1;
            chk("lit_rdy_after", o_miss_rdy, 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] pa;
        logic [33:0] prev_pa;
        int la, ea, fb, ib, wi, ex;
        bit fr, wf;
        rst = 1'b1;
        clr_in();
        i_miss_paddr       = '0;
        i_icache_inv_paddr = '0;
        i_bus_rsp_data     = '0;
        step();
        chk_en = 1'b1;
        chk("lit_rst_rdy", o_miss_rdy, 1'b1);
        chk("lit_rst_busy", o_busy, 1'b0);
        chk("lit_rst_addr", o_bus_req_addr, 34'h0);
        step();
        rst = 1'b0;
        step();

        // clean refill
        run_txn(34'h2_1234_5678, 7, -1, 0, -1, -1, 0, 0, 0, 0, 1, 0, 1);
        // bus error on beat 3
        run_txn(34'h1_0000_0100, 7, 3, 0, -1, -1, 0, 0, 0, 0, 0, 1, 0);
        // flush in REQ with rdy low
        run_txn(34'h0_dead_0040, 7, -1, 1, -1, -1, 0, 0, 0, 0, -1, -1, 0);
        // flush at beat 2
        run_txn(34'h3_0000_0080, 7, -1, 0, 2, -1, 0, 0, 0, 0, 0, 0, 0);
        // invalidate to same line during RESP
        run_txn(34'h0_4444_41c0, 7, -1, 0, -1, 4, 0, 0, 0, 0, 0, 0, 0);
        // other-line invalidate in WRITE
        run_txn(34'h0_5555_5500, 7, -1, 0, -1, -1, 1, 0, 0, 0, 1, 0, 0);
        // matching invalidate in WRITE
        run_txn(34'h0_6666_6600, 7, -1, 0, -1, -1, 2, 0, 0, 0, 0, 0, 0);
        // early last on beat 5
        run_txn(34'h0_7777_7700, 5, -1, 0, -1, -1, 0, 0, 0, 0, 0, 1, 0);
        // beat 7 without last, then strays
        run_txn(34'h0_8888_8800, 8, -1, 0, -1, -1, 0, 0, 3, 0, 0, 1, 0);

        // reset at beat 4, then stray beats
        i_miss_paddr = 34'h2_abcd_ef00;
        i_miss_vld = 1'b1; step(); i_miss_vld = 1'b0;
        i_bus_req_rdy = 1'b1; step(); i_bus_req_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_bus_rsp_vld = 1'b1; i_bus_rsp_data = {$urandom, $urandom}; step();
        end
        i_bus_rsp_data = {$urandom, $urandom};
        rst = 1'b1;
        #1;
        chk("lit_rst_mid_busy", o_busy, 1'b0);
        chk("lit_rst_mid_wren", o_icache_wren, 1'b0);
        chk_line("lit_rst_mid_wdat", o_icache_wdat, 512'h0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_bus_rsp_vld = 1'b1; i_bus_rsp_data = {$urandom, $urandom};
            i_bus_rsp_last = (k == 2); step();
        end
        clr_in();
        #1;
        chk("lit_stray_busy", o_busy, 1'b0);
        chk("lit_stray_tag", o_icache_wtag, 20'h0);
        step();

        // randomized refills
        prev_pa = 34'h0;
        for (int t = 0; t < 300; t++) begin
            pa = ($urandom_range(0, 4) == 0) ? prev_pa : {2'($urandom_range(0, 3)), $urandom};
            prev_pa = pa;
            case ($urandom_range(0, 19))
                0, 1, 2: la = $urandom_range(0, 6);
                3, 4:    la = 8;
                default: la = 7;
            endcase
            ea = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
            fr = ($urandom_range(0, 11) == 0);
            fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
            ib = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
            wi = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            wf = ($urandom_range(0, 11) == 0);
            ex = (la == 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1));
            run_txn(pa, la, ea, fr, fb, ib, wi, wf, ex, 1, -1, -1, 0);
            if ($urandom_range(0, 3) == 0) begin
                i_bus_rsp_vld = 1'b1; i_bus_rsp_data = {$urandom, $urandom};
                step();
                clr_in();
            end
        end

        repeat (2) step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
